// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit scheduler.
//                Provides the scheduler state encoding and the width of the
//                shared launch/gap counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Scheduler states.
    //   IDLE   - waiting for a request while the transmitter is idle
    //   LAUNCH - uart_en held high until the transmitter reports busy
    //   WAIT   - frame on the wire, waiting for busy to fall
    //   GAP    - guard interval between frames
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        GAP    = 2'd3
    } uart_sched_state_t;

    // Width of the launch-timeout / guard-gap counter.
    localparam int unsigned c_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_arbiter
//  Description : Combinational round-robin arbiter. The requester closest to
//                ptr (searching upward and wrapping modulo N) wins.
//  Ports       : req     - request vector
//                ptr     - index where the search starts
//                gnt     - one-hot grant (all zero when no request)
//                gnt_idx - index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    // Distance of each requester from ptr, measured upward with wrap. One
    // extra bit so that i+N never overflows before the subtraction.
    logic [IW:0] w_dist;
    logic [IW:0] w_best;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_dist  = '0;
        w_best  = '1;
        for (int i = 0; i < N; i++) begin
            if ((IW+1)'(i) >= {1'b0, ptr}) begin
                w_dist = (IW+1)'(i) - {1'b0, ptr};
            end else begin
                w_dist = (IW+1)'(i + N) - {1'b0, ptr};
            end
            if (req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                gnt_idx = IW'(i);
            end
        end
        if (|req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Round-robin scheduler sharing one uart_send transmitter
//                between N_REQ byte producers. Sequences launch / busy /
//                complete, inserts a guard gap after every frame and flags
//                transmitters that never raise busy.
//  Ports       : sys_clk, sys_rst_n  - clock, async active-low reset
//                req_valid/req_data  - producer offers (byte i at [8i+7:8i])
//                req_ready           - one-hot accept strobe
//                uart_en, uart_din   - launch level and byte to uart_send
//                uart_tx_busy        - busy flag from uart_send
//                grant_id            - requester whose byte is in flight
//                ctl_busy            - scheduler not idle
//                err_timeout/err_clr - sticky launch-timeout flag and clear
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int GAP_CYCLES = 32,
    parameter  int LAUNCH_TMO = 8,
    localparam int IW         = $clog2(N_REQ)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 uart_en,
    output logic [7:0]           uart_din,
    input  logic                 uart_tx_busy,
    output logic [IW-1:0]        grant_id,
    output logic                 ctl_busy,
    output logic                 err_timeout,
    input  logic                 err_clr
);

    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(LAUNCH_TMO - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [IW-1:0]      c_LAST_IDX = IW'(N_REQ - 1);

    uart_sched_state_t      r_state;
    uart_sched_state_t      w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [IW-1:0]          r_ptr;
    logic [7:0]             r_uart_din;
    logic [IW-1:0]          r_grant_id;
    logic                   r_err;

    logic [N_REQ-1:0]       w_gnt;
    logic [IW-1:0]          w_gnt_idx;
    logic [7:0]             w_sel_data;
    logic                   w_grant_ok;
    logic                   w_accept;
    logic                   w_tmo;

    uart_rr_arbiter #(
        .N       (N_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Grants are only offered from IDLE with the transmitter idle. Gating with
    // the reset keeps req_ready low for the whole time reset is asserted.
    assign w_grant_ok = sys_rst_n && (r_state == IDLE) && !uart_tx_busy;
    assign w_accept   = w_grant_ok && (|req_valid);
    assign w_tmo      = (r_state == LAUNCH) && !uart_tx_busy && (r_cnt == c_TMO_LAST);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = req_data[8*i +: 8];
            end
        end
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)                   w_state_nxt = LAUNCH;
            LAUNCH:  if (uart_tx_busy)               w_state_nxt = WAIT;
                     else if (r_cnt == c_TMO_LAST)   w_state_nxt = GAP;
            WAIT:    if (!uart_tx_busy)              w_state_nxt = GAP;
            GAP:     if (r_cnt == c_GAP_LAST)        w_state_nxt = IDLE;
            default:                                 w_state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // uart_en is decoded straight from the state so that an asynchronous
    // reset drops it without waiting for a clock edge.
    always_comb begin
        uart_en   = (r_state == LAUNCH);
        ctl_busy  = (r_state != IDLE);
        req_ready = w_grant_ok ? w_gnt : '0;
    end

    assign uart_din    = r_uart_din;
    assign grant_id    = r_grant_id;
    assign err_timeout = r_err;

    // -------------------------------------------------------------- counter
    // Cleared on every state entry so each state counts from zero.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                LAUNCH:  r_cnt <= (uart_tx_busy || (r_cnt == c_TMO_LAST)) ? '0 : r_cnt + 8'd1;
                GAP:     r_cnt <= (r_cnt == c_GAP_LAST) ? '0 : r_cnt + 8'd1;
                default: r_cnt <= '0;
            endcase
        end
    end

    // ------------------------------------------------ grant capture, pointer
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_uart_din <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
        end else if (w_accept) begin
            r_uart_din <= w_sel_data;
            r_grant_id <= w_gnt_idx;
            r_ptr      <= (w_gnt_idx == c_LAST_IDX) ? '0 : w_gnt_idx + IW'(1);
        end
    end

    // ------------------------------------------------------- timeout flag
    // A new timeout takes priority over a simultaneous clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_err <= 1'b0;
        end else if (w_tmo) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Self-checking bench for uart_tx_sched with a behavioural
//                uart_send model, a vector table of grant sequences, directed
//                corner cases and a randomized run against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int N   = 4;
    localparam int GAP = 32;
    localparam int TMO = 8;

    logic           sys_clk = 1'b0;
    logic           sys_rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           uart_en;
    logic [7:0]     uart_din;
    logic           uart_tx_busy;
    logic [1:0]     grant_id;
    logic           ctl_busy;
    logic           err_timeout;
    logic           err_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    uart_tx_sched #(
        .N_REQ        (N),
        .GAP_CYCLES   (GAP),
        .LAUNCH_TMO   (TMO)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .uart_en      (uart_en),
        .uart_din     (uart_din),
        .uart_tx_busy (uart_tx_busy),
        .grant_id     (grant_id),
        .ctl_busy     (ctl_busy),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr)
    );

    // ---------------------------------------------------- uart_send model
    // Edge-detects uart_en through two flops, raises busy one clock later and
    // shifts out {stop, data, start} LSB first, bps clocks per bit.
    int         bps = 260;
    logic       force_en = 1'b0;
    logic       force_val = 1'b0;
    logic       m_busy = 1'b0;
    logic       en_d1 = 1'b0;
    logic       en_d2 = 1'b0;
    logic [9:0] m_sh = '1;
    logic [9:0] m_rx = '0;
    int         m_baud = 0;
    int         m_nbit = 0;
    logic       txd;
    logic [9:0] sent_q[$];

    assign txd          = m_busy ? m_sh[0] : 1'b1;
    assign uart_tx_busy = force_en ? force_val : m_busy;

    always @(posedge sys_clk) begin
        en_d1 <= uart_en;
        en_d2 <= en_d1;
        if (!m_busy) begin
            if (en_d1 && !en_d2) begin
                m_busy <= 1'b1;
                m_sh   <= {1'b1, uart_din, 1'b0};
                m_baud <= 0;
                m_nbit <= 0;
            end
        end else if (m_baud == bps - 1) begin
            m_baud <= 0;
            m_sh   <= {1'b1, m_sh[9:1]};
            m_rx   <= {txd, m_rx[9:1]};
            m_nbit <= m_nbit + 1;
            if (m_nbit == 9) begin
                m_busy <= 1'b0;
                sent_q.push_back({txd, m_rx[9:1]});
            end
        end else begin
            m_baud <= m_baud + 1;
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic wait_quiet(input string nm);
        int n;
        n = 0;
        while ((ctl_busy !== 1'b0 || uart_tx_busy !== 1'b0) && n < 20000) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 20000) expire({nm, "_quiet"});
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (req_ready == '0 && n < 200);
        if (req_ready == '0) expire({nm, "_ready"});
    endtask

    task automatic pop_serial(input string nm, input logic [7:0] b);
        int n;
        n = 0;
        while (sent_q.size() == 0 && n < 12 * bps + 50) begin
            @(negedge sys_clk);
            n++;
        end
        if (sent_q.size() == 0) expire({nm, "_serial"});
        else check({nm, "_serial"}, 32'(sent_q.pop_front()), 32'({1'b1, b, 1'b0}));
    endtask

    // One complete transaction: offer, accept, launch pulse, serial byte.
    task automatic run_vec(input logic [N-1:0] valid, input logic [N-1:0] exp_rdy, input string nm);
        int g;
        int en_n;
        logic [7:0] b;
        wait_quiet(nm);
        @(posedge sys_clk); #1;
        req_valid = valid;
        wait_ready(nm);
        check({nm, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
        g = 0;
        for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
        b = req_data[8*g +: 8];
        @(posedge sys_clk); #1;
        req_valid = '0;
        @(negedge sys_clk);
        check({nm, "_din"}, 32'(uart_din), 32'(b));
        check({nm, "_gid"}, 32'(grant_id), 32'(g));
        check({nm, "_rdy_low"}, 32'(req_ready), 32'h0);
        en_n = 0;
        while (uart_en === 1'b1 && en_n < 50) begin
            en_n++;
            @(negedge sys_clk);
        end
        check({nm, "_en_len"}, 32'(en_n), 32'd3);
        pop_serial(nm, b);
    endtask

    // Timeout sequence with uart_tx_busy held low; returns after the gap.
    task automatic run_timeout(input string nm, input logic clr_held);
        int en_n;
        int gap_n;
        wait_quiet(nm);
        @(posedge sys_clk); #1;
        err_clr   = clr_held;
        req_valid = 4'b0100;
        wait_ready(nm);
        check({nm, "_rdy"}, 32'(req_ready), 32'h4);
        @(posedge sys_clk); #1;
        req_valid = '0;
        @(negedge sys_clk);
        check({nm, "_din"}, 32'(uart_din), 32'h5A);
        en_n = 0;
        while (uart_en === 1'b1 && en_n < 50) begin
            en_n++;
            @(negedge sys_clk);
        end
        check({nm, "_en_len"}, 32'(en_n), 32'(TMO));
        check({nm, "_err_set"}, 32'(err_timeout), 32'h1);
        if (clr_held) begin
            @(negedge sys_clk);
            check({nm, "_err_clr"}, 32'(err_timeout), 32'h0);
            @(posedge sys_clk); #1;
            err_clr = 1'b0;
            @(negedge sys_clk);
        end
        gap_n = 0;
        while (ctl_busy === 1'b1 && gap_n < 200) begin
            gap_n++;
            @(negedge sys_clk);
        end
        if (!clr_held) check({nm, "_gap_len"}, 32'(gap_n), 32'(GAP));
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_rdy;
    } vec_t;

    vec_t vecs[10];

    // ---------------------------------------------------------- main test
    initial begin
        logic [N-1:0] exp_r;
        logic [9:0]   fr;
        longint       idle_at;
        logic         busy_prev;
        int           ptr_m;
        int           pend_g;
        logic [7:0]   pend_b;
        logic [7:0]   exp_q[$];
        int           n;

        // Starting pointer 1 (after the single request to requester 0).
        vecs[0] = '{4'b1111, 4'b0010};
        vecs[1] = '{4'b1111, 4'b0100};
        vecs[2] = '{4'b1111, 4'b1000};
        vecs[3] = '{4'b1111, 4'b0001};
        vecs[4] = '{4'b0100, 4'b0100};
        vecs[5] = '{4'b1010, 4'b1000};
        vecs[6] = '{4'b1010, 4'b0010};
        vecs[7] = '{4'b1010, 4'b1000};
        vecs[8] = '{4'b0011, 4'b0001};
        vecs[9] = '{4'b0001, 4'b0001};

        // Reset values, with every requester asking.
        req_valid = 4'b1111;
        repeat (3) @(negedge sys_clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_en", 32'(uart_en), 32'h0);
        check("rst_din", 32'(uart_din), 32'h0);
        check("rst_gid", 32'(grant_id), 32'h0);
        check("rst_ctl_busy", 32'(ctl_busy), 32'h0);
        check("rst_err", 32'(err_timeout), 32'h0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        req_valid = '0;

        // Single request at the real baud divisor.
        bps      = 260;
        req_data = 32'h443322A5;
        run_vec(4'b0001, 4'b0001, "single");
        check("single_err", 32'(err_timeout), 32'h0);
        wait_quiet("single");
        bps      = 16;
        req_data = 32'h44332211;

        // Fairness and pointer-wrap sequences.
        for (int v = 0; v < 10; v++) begin
            run_vec(vecs[v].valid, vecs[v].exp_rdy, $sformatf("vec%0d", v));
        end

        // Launch timeouts: busy tied low.
        wait_quiet("tmo");
        force_en  = 1'b1;
        force_val = 1'b0;
        req_data  = 32'h445A2211;
        run_timeout("tmo", 1'b0);
        check("tmo_err_sticky", 32'(err_timeout), 32'h1);
        @(posedge sys_clk); #1;
        err_clr = 1'b1;
        @(posedge sys_clk); #1;
        err_clr = 1'b0;
        @(negedge sys_clk);
        check("tmo_err_cleared", 32'(err_timeout), 32'h0);
        run_timeout("tmo_setwins", 1'b1);
        n = 0;
        while (m_busy && n < 5000) begin
            @(negedge sys_clk);
            n++;
        end
        sent_q.delete();
        req_data = 32'h44332211;

        // Busy seen in IDLE blocks the grant.
        force_val = 1'b1;
        @(posedge sys_clk); #1;
        req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            check("bidle_ready_low", 32'(req_ready), 32'h0);
        end
        check("bidle_ctl_busy", 32'(ctl_busy), 32'h0);
        @(posedge sys_clk); #1;
        force_val = 1'b0;
        @(negedge sys_clk);
        check("bidle_ready", 32'(req_ready), 32'h1);
        @(posedge sys_clk); #1;
        force_en  = 1'b0;
        req_valid = '0;
        pop_serial("bidle", 8'h11);

        // Reset while the frame is on the wire.
        wait_quiet("rstw");
        @(posedge sys_clk); #1;
        req_valid = 4'b0110;
        wait_ready("rstw");
        check("rstw_first_rdy", 32'(req_ready), 32'h2);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (uart_en === 1'b1 && n < 50);
        repeat (5) @(negedge sys_clk);
        check("rstw_in_wait", 32'(ctl_busy & uart_tx_busy), 32'h1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("rstw_en", 32'(uart_en), 32'h0);
        check("rstw_ctl_busy", 32'(ctl_busy), 32'h0);
        check("rstw_gid", 32'(grant_id), 32'h0);
        check("rstw_ready", 32'(req_ready), 32'h0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        n = 0;
        @(negedge sys_clk);
        while (uart_tx_busy === 1'b1 && n < 1000) begin
            if (req_ready !== '0 || ctl_busy !== 1'b0) check("rstw_blocked", 32'({req_ready, ctl_busy}), 32'h0);
            @(negedge sys_clk);
            n++;
        end
        check("rstw_busy_seen", 32'(n > 10), 32'h1);
        check("rstw_regrant", 32'(req_ready), 32'h2);
        @(posedge sys_clk); #1;
        req_valid = '0;
        wait_quiet("rstw_end");
        sent_q.delete();

        // Randomized run from a clean reset against the reference model.
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        ptr_m     = 0;
        idle_at   = 0;
        busy_prev = 1'b0;
        pend_g    = -1;
        pend_b    = '0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge sys_clk);
            if (pend_g >= 0) begin
                check("rand_gid", 32'(grant_id), 32'(pend_g));
                check("rand_din", 32'(uart_din), 32'(pend_b));
                pend_g = -1;
            end
            if (busy_prev && !uart_tx_busy) idle_at = longint'(c) + 1 + GAP;
            busy_prev = uart_tx_busy;
            exp_r = '0;
            if (longint'(c) >= idle_at && !uart_tx_busy && req_valid != '0) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (ptr_m + k) % N;
                    if (req_valid[i]) begin
                        exp_r[i] = 1'b1;
                        break;
                    end
                end
            end
            check("rand_ready", 32'(req_ready), 32'(exp_r));
            for (int i = 0; i < N; i++) begin
                if (exp_r[i]) begin
                    ptr_m   = (i + 1) % N;
                    idle_at = 64'h7FFF_FFFF;
                    pend_g  = i;
                    pend_b  = req_data[8*i +: 8];
                    exp_q.push_back(req_data[8*i +: 8]);
                end
            end
            while (sent_q.size() > 0) begin
                fr = sent_q.pop_front();
                if (exp_q.size() == 0) check("rand_serial_extra", 32'(fr), 32'h0);
                else check("rand_serial", 32'(fr), 32'({1'b1, exp_q.pop_front(), 1'b0}));
            end
            @(posedge sys_clk); #1;
            for (int i = 0; i < N; i++) begin
                if (exp_r[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) begin
                        req_valid[i]        = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        wait_quiet("rand_end");
        while (sent_q.size() > 0) begin
            fr = sent_q.pop_front();
            if (exp_q.size() == 0) check("rand_serial_extra", 32'(fr), 32'h0);
            else check("rand_serial", 32'(fr), 32'({1'b1, exp_q.pop_front(), 1'b0}));
        end
        check("rand_all_sent", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler that shares one `uart_send` transmitter between `N_REQ` byte producers. Each producer offers a byte over a valid/ready handshake. The scheduler grants one byte at a time and drives `uart_send`'s `uart_en`/`uart_din`. It sequences the launch/busy/complete handshake, inserts a guard gap after each frame, and flags transmitters that fail to start.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 32: idle clocks after `uart_tx_busy` falls before the next grant, 1..255. Must be ≥ `BPS_CNT/16 + 2` of the attached `uart_send`.
- `LAUNCH_TMO`, 8: clocks allowed in LAUNCH for `uart_tx_busy` to rise, 4..255.
- `sys_clk` in 1: system clock. Single clock domain; all logic on the rising edge.
- `sys_rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in `N_REQ`: requester i offers the byte in `req_data[8i+7:8i]`.
- `req_data` in `8*N_REQ`: requester bytes, packed.
- `req_ready` out `N_REQ`: one-hot accept strobe. Transfer occurs when `req_valid[i] & req_ready[i]`.
- `uart_en` out 1: launch level to `uart_send`.
- `uart_din` out 8: byte to `uart_send`.
- `uart_tx_busy` in 1: busy flag from `uart_send`.
- `grant_id` out `$clog2(N_REQ)`: index of the requester whose byte is in flight.
- `ctl_busy` out 1: high whenever the state is not IDLE.
- `err_timeout` out 1: sticky launch-timeout flag.
- `err_clr` in 1: synchronous clear of `err_timeout`.

## Operation
- States: IDLE, LAUNCH, WAIT, GAP.
- **IDLE:** if `uart_tx_busy=0` and any `req_valid`, the round-robin winner g gets `req_ready[g]=1`. `req_ready` is combinational from `req_valid`, state and pointer.
  - At that edge: `uart_din<=req_data[g]`, `grant_id<=g`, pointer<=(g+1) mod `N_REQ`, counter<=0, go to LAUNCH.
  - If `uart_tx_busy=1` in IDLE: no grant, `req_ready=0`.
- **LAUNCH:** `uart_en=1`; counter increments each clock.
  - `uart_tx_busy=1` → WAIT.
  - Counter reaches `LAUNCH_TMO-1` with busy still 0 → `err_timeout<=1`, byte dropped, go to GAP.
- **WAIT:** `uart_en=0`. `uart_tx_busy=0` → counter<=0, go to GAP.
- **GAP:** `uart_en=0`. Counter counts to `GAP_CYCLES-1`, then go to IDLE.
- Round-robin: search starts at the pointer and wraps modulo `N_REQ`. The pointer advances only on a grant; timeouts do not rewind it.
- Requesters hold `req_valid`/`req_data` stable until accepted. Dropping `req_valid` before acceptance is legal (no grant).
- `uart_din` and `grant_id` hold from acceptance until the next acceptance.
- `err_timeout`: a set in the same cycle as `err_clr` wins.

## Timing
- Reset values: state IDLE, `uart_en=0`, `uart_din=0`, `grant_id=0`, pointer 0, `ctl_busy=0`, `err_timeout=0`, counter 0. `req_ready` reads 0 while `sys_rst_n=0`.
- Reset mid-frame: `uart_en` drops immediately and the scheduler returns to IDLE. After release, the IDLE busy check blocks new grants until `uart_send` goes idle.
- Cycle T: accept (`req_ready` high).
  - T+1: `uart_en=1`, `uart_din` valid.
  - `uart_send` edge-detects at T+2 and raises busy at T+3.
  - At the T+3 edge the scheduler sees busy and enters WAIT; `uart_en` is low from T+4. The `uart_en` pulse is 3 clocks.
- Busy falls at F → GAP from F+1 → IDLE after `GAP_CYCLES` clocks → earliest next acceptance at F+1+`GAP_CYCLES`.
- Throughput: one byte per frame; at most one byte in flight.
- Counter width: 8 bits; never wraps within a state.

## Structure
- Shared package `uart_pkg`: state enum `uart_sched_state_t` {IDLE, LAUNCH, WAIT, GAP}.
- One sub-module, `uart_rr_arbiter`:
  - Parameter `N`.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `gnt[N]`, `gnt_idx`.
  - Purely combinational.
- FSM, counter, pointer and error logic live in `uart_tx_sched`.

## Test plan
- Single request: req 0 offers 8'hA5 with a `uart_send` model (BPS_CNT=260) attached → `req_ready[0]` for 1 cycle, `uart_en` high 3 cycles, serial line carries A5, `err_timeout=0`.
- Fairness: all 4 valid continuously with distinct bytes 11/22/33/44 → grant order 0,1,2,3,0. Consecutive acceptances are ≥ frame+`GAP_CYCLES`+1 apart.
- Pointer wrap: pointer=3, only req 1 and req 3 valid → grant 3, then 1, then 3.
- Timeout: busy tied 0, req 2 offers 8'h5A → after `LAUNCH_TMO` LAUNCH clocks `err_timeout=1`, `uart_en` falls, GAP, then IDLE. `err_clr` with no new timeout → flag clears next cycle.
- Busy-at-idle: `uart_tx_busy` forced 1 while in IDLE with req 0 valid → `req_ready=0` until busy drops.
- Reset mid-WAIT: assert `sys_rst_n=0` during a frame → `uart_en=0`, `ctl_busy=0`, `grant_id=0` immediately; no grant until `uart_tx_busy` returns 0.
